// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing one quotient
// bit per clock. The result is a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
// Both sides use a valid/ready handshake. A zero divisor bypasses the iteration
// and returns a saturated quotient with the div_by_zero flag set.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  // The shift register carries the unconsumed dividend bits at the top and
  // collects quotient bits at the bottom. After 2*WIDTH shifts it holds the
  // complete quotient.
  logic [DW-1:0]    sreg_q, sreg_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  // Single restoring step: trial subtraction of the divisor from the shifted partial remainder.
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             qbit_s;
  logic [WIDTH:0]   rem_next_s;

  // Restoring-step datapath: compare, subtract, select.
  always_comb begin
    trial_s    = {rem_q[WIDTH-1:0], sreg_q[DW-1]};
    diff_s     = trial_s - {1'b0, dvs_q};
    qbit_s     = (trial_s >= {1'b0, dvs_q});
    rem_next_s = qbit_s ? diff_s : trial_s;
  end

  // Next-state logic: operand capture, iteration and result handoff.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sreg_d  = sreg_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == {WIDTH{1'b0}}) begin
            quo_d   = {DW{1'b1}};
            remo_d  = dividend[WIDTH-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = {(WIDTH+1){1'b0}};
            sreg_d  = dividend;
            dvs_d   = divisor;
            cnt_d   = {CW{1'b0}};
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d  = rem_next_s;
        sreg_d = {sreg_q[DW-2:0], qbit_s};
        if (cnt_q == CNT_LAST) begin
          quo_d   = {sreg_q[DW-2:0], qbit_s};
          remo_d  = rem_next_s[WIDTH-1:0];
          dbz_d   = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= {(WIDTH+1){1'b0}};
      sreg_q  <= {DW{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      quo_q   <= {DW{1'b0}};
      remo_q  <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sreg_q  <= sreg_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags decode directly from the state register; results come straight from registers.
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    quotient    = quo_q;
    remainder   = remo_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8).
// The reference result comes from plain integer division and modulo.
module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = 16'd0;
  logic [7:0]  divisor = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  longint last_accept = 0;
  longint prev_accept = 0;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one full transaction. The bench is in the posedge+1 phase on entry and on exit.
  task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                       input int hold, input bit noise, input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          exp_lat;
    int          lat;
    int          g;
    if (dvs == 8'd0) begin
      eq = 16'hFFFF; er = dvd[7:0]; ed = 1'b1; exp_lat = 0;
    end else begin
      eq = dvd / {8'd0, dvs};
      er = 8'(dvd % {8'd0, dvs});
      ed = 1'b0; exp_lat = 16;
    end
    dividend = dvd; divisor = dvs; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 50) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    prev_accept = last_accept;
    last_accept = $time;
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      if (noise) begin
        dividend = 16'($urandom); divisor = 8'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, {15'd0, quotient, remainder, div_by_zero}, {15'd0, eq, er, ed});
    if (dvs != 8'd0)
      check({tag, "_invariant"},
            32'((32'(quotient) * 32'(dvs) + 32'(remainder) == 32'(dvd)) && (remainder < dvs)),
            32'd1);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        dividend = 16'($urandom); divisor = 8'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      check({tag, "_hold"}, {5'd0, out_valid, in_ready, quotient, remainder, div_by_zero},
            {5'd0, 1'b1, 1'b0, eq, er, ed});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_handoff"}, {5'd0, out_valid, in_ready, quotient, remainder, div_by_zero},
          {5'd0, 1'b0, 1'b1, eq, er, ed});
  endtask

  initial begin
    // Reset state
    #12;
    check("reset", {27'd0, in_ready, out_valid, div_by_zero, (quotient == 16'd0), (remainder == 8'd0)},
          {27'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1
    do_op(16'd200, 8'd7, 0, 1'b0, "t1_200_7");
    check("t1_q", 32'(quotient), 32'd28);
    check("t1_r", 32'(remainder), 32'd4);

    // T2, then throughput with back-to-back operations
    do_op(16'd65535, 8'd255, 0, 1'b0, "t2_65535_255");
    check("t2_q", 32'(quotient), 32'd257);
    do_op(16'd3, 8'd200, 0, 1'b0, "t2_3_200");
    check("t2_throughput", 32'(last_accept - prev_accept), 32'd180);
    check("t2_r", 32'(remainder), 32'd3);

    // T3 divide by zero
    do_op(16'd1000, 8'd0, 0, 1'b0, "t3_div0");
    check("t3_out", {15'd0, quotient, remainder, div_by_zero}, {15'd0, 16'hFFFF, 8'hE8, 1'b1});

    // T4 backpressure for 10 cycles
    do_op(16'd12345, 8'd99, 10, 1'b1, "t4_bp");

    // T5 reset mid-calculation
    dividend = 16'd50000; divisor = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_abort", {28'd0, out_valid, in_ready, (quotient == 16'd0), (remainder == 8'd0)},
          {28'd0, 1'b0, 1'b1, 1'b1, 1'b1});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'd50000, 8'd3, 0, 1'b0, "t5_rerun");
    check("t5_result", {16'd0, quotient, remainder}, {16'd0, 16'd16666, 8'd2});

    // T6 random back-to-back operations with random backpressure and operand noise
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] rd;
      logic [7:0]  rv;
      rd = 16'($urandom);
      rv = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_op(rd, rv, $urandom_range(0, 3), 1'b1, "t6_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
